instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction fetch/issue front end for the CPU. It holds the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents decoded fields (opcode, register specifiers, extended immediate) to the control unit and datapath. It consumes the control unit's PCWre/PCSrc/ExtSel decisions to select the next PC, and it parks in a halted state when PCWre is deasserted.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held high until acknowledged
- imem_addr  out  32  fetch address (= PC); stable while imem_req=1
- imem_ack  in  1  instruction word valid on imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  IR holds an instruction under execution
- instr_done  in  1  datapath finished the current instruction; pc_wre/pc_src sampled this cycle
- pc_wre  in  1  1 = advance PC, 0 = halt
- pc_src  in  1  0 = PC+4, 1 = branch target
- ext_sel  in  1  1 = sign-extend imm, 0 = zero-extend
- opcode  out  6  IR[31:26]
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- ext_imm  out  32  IR[15:0] extended per ext_sel (combinational)
- pc  out  32  current PC
- halted  out  1  block in HALT

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: entered on reset; PC=RESET_PC; one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack: IR<=imem_rdata, go ISSUE.
- ISSUE: instr_valid=1; IR and PC frozen. On instr_done:
  - pc_wre=0: PC unchanged, go HALT.
  - pc_wre=1, pc_src=0: PC<=PC+4, go FETCH.
  - pc_wre=1, pc_src=1: PC<=PC+4+(sext(IR[15:0])<<2), go FETCH (branch offset always sign-extended, independent of ext_sel).
- HALT: halted=1, imem_req=0, instr_valid=0; exits only via Reset.
- Arithmetic: 32-bit modulo; PC 32'hFFFF_FFFC +4 wraps to 0; branch target wraps likewise; PC[1:0] forced 0.
- imem_ack outside FETCH ignored; instr_done outside ISSUE ignored.
- Reset asserted in any state (mid-fetch included): immediately imem_req=0, instr_valid=0, halted=0, IR=0, PC=RESET_PC, state IDLE; an ack arriving during reset is discarded.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, halted=0, pc=RESET_PC, opcode/rs/rt/rd=0, ext_imm=0.
- First imem_req: first rising edge after Reset deasserts moves IDLE->FETCH; req high the following cycle.
- Zero-wait memory: ack in the first req cycle is accepted.
- Ack in cycle N -> instr_valid=1 in N+1, fields valid same cycle.
- instr_done in cycle M -> new PC and imem_req=1 in M+1 (or halted=1 in M+1). instr_valid=0 in M+1.
- Minimum instruction period with zero-wait memory and instr_done in first ISSUE cycle: 2 cycles.
- ext_imm follows ext_sel combinationally in the same cycle.

## Structure
- Shared package cpu_pkg: opcode constants (OP_ADD 6'b000000, OP_ADDI 6'b000001, OP_SUB 6'b000010, OP_ORI 6'b010000, OP_AND 6'b010001, OP_OR 6'b010010, OP_MOVE 6'b100000, OP_SW 6'b100110, OP_LW 6'b100111, OP_BEQ 6'b110000, OP_HALT 6'b111111), instruction field bit positions, fetch state enum.
- One sub-module: pc_next_calc (combinational PC+4 / branch-target adder and mux).

## Test plan
- Reset, zero-wait memory returning OP_ADD words, instr_done each ISSUE cycle with pc_wre=1,pc_src=0 -> imem_addr sequence 0,4,8,12; instr_valid every other cycle.
- Memory with 3-cycle ack latency -> imem_req and imem_addr held stable 3 cycles; instr_valid only after ack.
- BEQ word imm=16'hFFFE at PC=0x20, pc_src=1 -> next imem_addr 0x1C; imm=16'h0003 -> 0x30.
- ext_sel toggle with imm=16'h8001 -> ext_imm 32'hFFFF8001 (1) / 32'h00008001 (0).
- OP_HALT issued, instr_done with pc_wre=0 -> halted=1, imem_req stays 0 for 20 cycles, pc unchanged, further acks/instr_done ignored.
- Reset asserted mid-FETCH with ack same cycle -> IR not loaded, pc=RESET_PC, refetch from RESET_PC; PC=0xFFFF_FFFC sequential -> next address 0x0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions and
// the fetch-unit state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm,
                                             input logic        sign_ext);
    extend_imm = sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential PC+4 or PC-relative branch target.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [15:0] imm_i,
  input  logic        pc_src_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] sel;

  // Branch offset is a signed word count regardless of the datapath's ExtSel.
  assign pc_plus4  = pc_i + 32'd4;
  assign br_offset = {{14{imm_i[15]}}, imm_i, 2'b00};
  assign sel       = pc_src_i ? (pc_plus4 + br_offset) : pc_plus4;
  assign pc_next_o = {sel[31:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue front end: PC, req/ack instruction fetch, IR and
// decoded fields; parks in HALT when the control unit stops PC writes.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         Reset,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic         instr_valid,
  input  logic         instr_done,
  input  logic         pc_wre,
  input  logic         pc_src,
  input  logic         ext_sel,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [31:0]  ext_imm,
  output logic [31:0]  pc,
  output logic         halted,
  output fetch_state_e dbg_state
);

  // Handshake: a fetch completes on any cycle where imem_req && imem_ack;
  // imem_req/imem_addr stay constant until then. An instruction retires on
  // any cycle where instr_valid && instr_done.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  pc_next;

  pc_next_calc u_pc_next_calc (
    .pc_i      (pc_q),
    .imm_i     (ir_q[IMM_MSB:IMM_LSB]),
    .pc_src_i  (pc_src),
    .pc_next_o (pc_next)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_done) begin
          if (pc_wre) begin
            pc_d    = pc_next;
            state_d = S_FETCH;
          end else begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign rs        = ir_q[RS_MSB:RS_LSB];
  assign rt        = ir_q[RT_MSB:RT_LSB];
  assign rd        = ir_q[RD_MSB:RD_LSB];
  assign ext_imm   = extend_imm(ir_q[IMM_MSB:IMM_LSB], ext_sel);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: fetch addresses are predicted
// into a queue as instructions retire and matched when the DUT requests.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = 32'h0;
  logic         instr_valid;
  logic         instr_done = 1'b0;
  logic         pc_wre = 1'b0;
  logic         pc_src = 1'b0;
  logic         ext_sel = 1'b0;
  logic [5:0]   opcode;
  logic [4:0]   rs, rt, rd;
  logic [31:0]  ext_imm;
  logic [31:0]  pc;
  logic         halted;
  fetch_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [15:0] cur_imm;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .Reset(Reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_done(instr_done),
    .pc_wre(pc_wre), .pc_src(pc_src), .ext_sel(ext_sel),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .ext_imm(ext_imm), .pc(pc), .halted(halted), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk_word(input logic [5:0] op, input logic [15:0] imm);
    mk_word = {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm};
  endfunction

  task automatic apply_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    exp_q.delete();
    exp_pc = 32'h0;
    exp_q.push_back(exp_pc);
    step();
  endtask

  // Wait for a request, check its address, answer after lat cycles.
  task automatic fetch_instr(input logic [31:0] word, input int lat);
    int n = 0;
    logic [31:0] a;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    check("fetch_req", 32'(imem_req), 32'd1);
    if (exp_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
    else check("fetch_addr", imem_addr, exp_q.pop_front());
    a = imem_addr;
    for (int i = 0; i < lat; i++) begin
      step();
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, a);
      check("no_valid_wait", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom();
    cur_imm = word[15:0];
    check("issue_valid", 32'(instr_valid), 32'd1);
    check("issue_req_low", 32'(imem_req), 32'd0);
    check("opcode", 32'(opcode), 32'(word[31:26]));
    check("rs", 32'(rs), 32'(word[25:21]));
    check("rt", 32'(rt), 32'(word[20:16]));
    check("rd", 32'(rd), 32'(word[15:11]));
  endtask

  task automatic exec_instr(input logic wre, input logic src);
    instr_done = 1'b1;
    pc_wre = wre;
    pc_src = src;
    step();
    instr_done = 1'b0;
    pc_wre = 1'b0;
    pc_src = 1'b0;
    check("valid_drop", 32'(instr_valid), 32'd0);
    if (wre) begin
      exp_pc = src ? exp_pc + 32'd4 + {{14{cur_imm[15]}}, cur_imm, 2'b00} : exp_pc + 32'd4;
      exp_q.push_back(exp_pc);
      check("next_req", 32'(imem_req), 32'd1);
      check("next_pc", pc, exp_pc);
    end else begin
      check("halted", 32'(halted), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] w;
    step();
    // reset values
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_fields", 32'({rs, rt, rd}), 32'd0);
    check("rst_ext_imm", ext_imm, 32'h0);
    Reset = 1'b0;
    exp_pc = 32'h0;
    exp_q.push_back(exp_pc);
    step();
    check("first_req", 32'(imem_req), 32'd1);

    // zero-wait sequential: 0,4,8,12
    for (int i = 0; i < 4; i++) begin
      fetch_instr(mk_word(OP_ADD, 16'($urandom())), 0);
      exec_instr(1'b1, 1'b0);
    end
    check("seq_addr16", imem_addr, 32'h10);

    // 3-cycle memory latency, then random latencies up to 0x20
    fetch_instr(mk_word(OP_SUB, 16'h1234), 3);
    exec_instr(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      fetch_instr(mk_word(OP_LW, 16'($urandom())), $urandom_range(0, 2));
      exec_instr(1'b1, 1'b0);
    end
    check("at_0x20", imem_addr, 32'h20);

    // backward branch, then forward branch
    fetch_instr(mk_word(OP_BEQ, 16'hFFFE), 0);
    exec_instr(1'b1, 1'b1);
    check("beq_back", imem_addr, 32'h1C);
    fetch_instr(mk_word(OP_ADDI, 16'h0003), 1);
    exec_instr(1'b1, 1'b0);
    fetch_instr(mk_word(OP_BEQ, 16'h0003), 0);
    exec_instr(1'b1, 1'b1);
    check("beq_fwd", imem_addr, 32'h30);

    // extension select, and branch-free retire with ext_sel ignored by pc
    fetch_instr(mk_word(OP_ORI, 16'h8001), 0);
    ext_sel = 1'b1;
    #1 check("ext_sign", ext_imm, 32'hFFFF_8001);
    ext_sel = 1'b0;
    #1 check("ext_zero", ext_imm, 32'h0000_8001);
    ext_sel = 1'b1;
    #1 check("ext_sign2", ext_imm, 32'hFFFF_8001);
    exec_instr(1'b1, 1'b0);

    // halt and stay halted
    fetch_instr(mk_word(OP_HALT, 16'h0), 0);
    exec_instr(1'b0, 1'b0);
    check("halt_state", 32'(dbg_state), 32'(S_HALT));
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      instr_done = 1'($urandom_range(0, 1));
      pc_wre = 1'b1;
      pc_src = 1'($urandom_range(0, 1));
      step();
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_pc", pc, 32'h34);
    end
    imem_ack = 1'b0;
    instr_done = 1'b0;
    pc_wre = 1'b0;
    pc_src = 1'b0;

    // reset out of halt; branch to 0xFFFFFFFC, then wrap to 0
    apply_reset();
    check("post_halt_req", 32'(imem_req), 32'd1);
    check("post_halt_flag", 32'(halted), 32'd0);
    fetch_instr(mk_word(OP_BEQ, 16'hFFFE), 0);
    exec_instr(1'b1, 1'b1);
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    fetch_instr(mk_word(OP_AND, 16'h0), 2);
    exec_instr(1'b1, 1'b0);
    check("wrap_zero", imem_addr, 32'h0);
    fetch_instr(mk_word(OP_OR, 16'h0), 0);
    exec_instr(1'b1, 1'b0);

    // reset mid-fetch with an ack in the same cycle
    check("mid_req", 32'(imem_req), 32'd1);
    check("mid_addr", imem_addr, 32'h4);
    w = mk_word(OP_SW, 16'hBEEF);
    Reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = w;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_pc", pc, 32'h0);
    step();
    imem_ack = 1'b0;
    check("rst_ack_opcode", 32'(opcode), 32'd0);
    check("rst_ack_valid", 32'(instr_valid), 32'd0);
    check("rst_ack_imm", ext_imm, 32'h0);
    Reset = 1'b0;
    exp_q.delete();
    exp_pc = 32'h0;
    exp_q.push_back(exp_pc);
    step();
    fetch_instr(mk_word(OP_MOVE, 16'h7777), 1);
    exec_instr(1'b1, 1'b0);
    check("refetch_next", imem_addr, 32'h4);
    check("sb_drained", 32'(exp_q.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
